// File: rtl/rsignpipe_pkg.sv
// Shared FPU definitions used by the result-sign pipeline: operation
// encoding and rounding-mode constants.
package rsignpipe_pkg;

   typedef enum logic [2:0] {
      OP_FMA   = 3'd0,
      OP_DIV   = 3'd1,
      OP_SQRT  = 3'd2,
      OP_CVT   = 3'd3,
      OP_SGNJ  = 3'd4,
      OP_SGNJN = 3'd5,
      OP_SGNJX = 3'd6,
      OP_NONE  = 3'd7
   } rsign_op_t;

   localparam logic [2:0] FRM_RNE = 3'b000;
   localparam logic [2:0] FRM_RTZ = 3'b001;
   localparam logic [2:0] FRM_RDN = 3'b010;
   localparam logic [2:0] FRM_RUP = 3'b011;
   localparam logic [2:0] FRM_RMM = 3'b100;

endpackage

// File: rtl/rsignpipe_rsignstage.sv
// One elastic register stage: a valid bit plus an NLANE-wide sign vector.
// The sign vector is only rewritten when a valid entry is loaded, so a
// stalled or drained stage keeps presenting its last value.
module rsignstage #(
   parameter int NLANE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             load,
   input  logic             in_valid,
   input  logic [NLANE-1:0] in_sign,
   output logic             valid,
   output logic [NLANE-1:0] sign
);

   logic             valid_d, valid_q;
   logic [NLANE-1:0] sign_d, sign_q;

   // next-state: load from upstream when advancing; flush kills only the valid bit
   always_comb begin
      valid_d = valid_q;
      sign_d  = sign_q;
      if (load) begin
         valid_d = in_valid;
         if (in_valid) begin
            sign_d = in_sign;
         end
      end
      if (flush) begin
         valid_d = 1'b0;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         sign_q  <= '0;
      end else begin
         valid_q <= valid_d;
         sign_q  <= sign_d;
      end
   end

   assign valid = valid_q;
   assign sign  = sign_q;

endmodule

// File: rtl/rsignpipe.sv
// Pipelined result-sign unit: resolves the per-lane sign for FMA, divide,
// square-root, convert and sign-injection results, then carries it through
// STAGES elastic stages so it lines up with the pipelined rounder.
module rsignpipe
   import rsignpipe_pkg::*;
#(
   parameter int NLANE  = 1,
   parameter int STAGES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           Flush,
   input  logic                           InValid,
   output logic                           InReady,
   input  rsign_op_t                      Op,
   input  logic [2:0]                     Frm,
   input  logic [NLANE-1:0]               Xs,
   input  logic [NLANE-1:0]               Ys,
   input  logic [NLANE-1:0]               FmaSs,
   input  logic [NLANE-1:0]               FmaZeroSum,
   input  logic [NLANE-1:0]               CvtCs,
   output logic                           OutValid,
   input  logic                           OutReady,
   output logic [NLANE-1:0]               Ms,
   output logic [$clog2(STAGES+1)-1:0]    Occ
);

   localparam int OCC_W = $clog2(STAGES+1);

   logic [NLANE-1:0]  sign_in;
   logic [STAGES-1:0] v;
   logic [STAGES-1:0] adv;
   logic [NLANE-1:0]  sgn [STAGES];
   logic              full_run;
   logic              accept;
   logic [OCC_W-1:0]  occ_sum;

   // per-lane sign selection; an exact-zero FMA sum is -0 only when rounding down
   always_comb begin
      sign_in = '0;
      for (int l = 0; l < NLANE; l++) begin
         case (Op)
            OP_FMA:   sign_in[l] = FmaZeroSum[l] ? (Frm == FRM_RDN) : FmaSs[l];
            OP_DIV:   sign_in[l] = Xs[l] ^ Ys[l];
            OP_SQRT:  sign_in[l] = Xs[l];
            OP_CVT:   sign_in[l] = CvtCs[l];
            OP_SGNJ:  sign_in[l] = Ys[l];
            OP_SGNJN: sign_in[l] = ~Ys[l];
            OP_SGNJX: sign_in[l] = Xs[l] ^ Ys[l];
            OP_NONE:  sign_in[l] = 1'b0;
            default:  sign_in[l] = 1'b0;
         endcase
      end
   end

   // a stage may load unless it and every stage below it are full and the
   // consumer is stalling; written as a running AND to avoid a comb loop on adv
   always_comb begin
      full_run = 1'b1;
      adv      = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         full_run = full_run & v[i];
         adv[i]   = OutReady | ~full_run;
      end
   end

   assign InReady = adv[0];
   assign accept  = InValid & adv[0] & ~Flush;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
         rsignstage #(.NLANE(NLANE)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (Flush),
            .load     (adv[g]),
            .in_valid (accept),
            .in_sign  (sign_in),
            .valid    (v[g]),
            .sign     (sgn[g])
         );
      end else begin : g_next
         rsignstage #(.NLANE(NLANE)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (Flush),
            .load     (adv[g]),
            .in_valid (v[g-1]),
            .in_sign  (sgn[g-1]),
            .valid    (v[g]),
            .sign     (sgn[g])
         );
      end
   end

   // occupancy is simply the number of valid stages
   always_comb begin
      occ_sum = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_sum = occ_sum + OCC_W'(v[i]);
      end
   end

   assign Occ      = occ_sum;
   assign OutValid = v[STAGES-1];
   assign Ms       = sgn[STAGES-1];

endmodule
